// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round sequencer: FSM states,
// hole count, LFSR feedback taps and the countdown's terminal/load values.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    PLAY = 3'd2,
    WAIT = 3'd3,
    OVER = 3'd4
  } state_e;

  localparam int          NUM_HOLES    = 4;
  // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0].
  localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
  localparam logic [31:0] COUNT_EXPIRE = 32'd0;
  localparam logic [31:0] COUNT_LOAD   = 32'd5;
  localparam logic [7:0]  SCORE_MAX    = 8'hFF;

  // One-hot LED pattern for a hole index.
  function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [1:0] idx);
    logic [NUM_HOLES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Never repeat the previous round's hole: bump to the next one instead.
  function automatic logic [1:0] pick_hole(input logic [1:0] cand,
                                           input logic [1:0] prev);
    return (cand == prev) ? cand + 2'd1 : cand;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to choose which hole lights up.
// It advances every cycle, so the chosen hole depends on how long the
// player idles before pressing start.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] idx
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feeding in the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // State register; the seed must be nonzero or the sequence locks up.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign idx = lfsr_q[1:0];

endmodule

// File: rtl/mole_round_ctrl.sv
// Round sequencer for whack-a-mole. Restarts the external countdown at the
// start of each round, lights one hole, scores debounced hits on their
// rising edge, counts rounds down and raises game_over when they run out.
// Every output comes straight from a flop.
module mole_round_ctrl
  import whack_pkg::*;
#(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] countin,
  input  logic [3:0]  hit,
  output logic        count_restart,
  output logic [3:0]  mole,
  output logic [7:0]  score,
  output logic [3:0]  rounds_left,
  output logic        game_over
);

  localparam logic [3:0] ROUNDS_INIT = 4'(NUM_ROUNDS);

  state_e     state_q,         state_d;
  logic       count_restart_q, count_restart_d;
  logic [3:0] mole_q,          mole_d;
  logic [7:0] score_q,         score_d;
  logic [3:0] rounds_left_q,   rounds_left_d;
  logic       game_over_q,     game_over_d;
  logic [3:0] hit_prev_q,      hit_prev_d;
  logic [1:0] prev_idx_q,      prev_idx_d;

  logic [1:0] lfsr_idx;
  logic [1:0] pick;
  logic [3:0] hit_edge;
  logic       expiry;
  logic       valid_hit;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .idx   (lfsr_idx)
  );

  // Next-state logic for the FSM, score, round counter and hole choice.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d         = state_q;
    count_restart_d = 1'b0;
    mole_d          = mole_q;
    score_d         = score_q;
    rounds_left_d   = rounds_left_q;
    game_over_d     = game_over_q;
    prev_idx_d      = prev_idx_q;
    hit_prev_d      = hit;
    pick            = pick_hole(lfsr_idx, prev_idx_q);

    hit_edge  = hit & ~hit_prev_q;
    expiry    = (countin == COUNT_EXPIRE);
    // mole_q is always one-hot in PLAY, so exact equality rejects both a
    // wrong button and the right button pressed together with another.
    valid_hit = (state_q == PLAY) && (hit_edge == mole_q);

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d         = ARM;
          count_restart_d = 1'b1;
          score_d         = '0;
          rounds_left_d   = ROUNDS_INIT;
          game_over_d     = 1'b0;
          mole_d          = '0;
        end
      end

      // countin is stale here while the restart lands, so expiry is ignored.
      ARM: begin
        state_d    = PLAY;
        mole_d     = hole_onehot(pick);
        prev_idx_d = pick;
      end

      PLAY, WAIT: begin
        if (valid_hit) begin
          state_d = WAIT;
          mole_d  = '0;
          if (score_q != SCORE_MAX) score_d = score_q + 8'd1;
        end
        // Expiry is applied after the hit so a same-cycle hit still scores.
        if (expiry) begin
          rounds_left_d = rounds_left_q - 4'd1;
          mole_d        = '0;
          if (rounds_left_d == 4'd0) begin
            state_d     = OVER;
            game_over_d = 1'b1;
          end else begin
            state_d         = ARM;
            count_restart_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // All registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      count_restart_q <= 1'b0;
      mole_q          <= '0;
      score_q         <= '0;
      rounds_left_q   <= ROUNDS_INIT;
      game_over_q     <= 1'b0;
      hit_prev_q      <= '0;
      prev_idx_q      <= '0;
    end else begin
      state_q         <= state_d;
      count_restart_q <= count_restart_d;
      mole_q          <= mole_d;
      score_q         <= score_d;
      rounds_left_q   <= rounds_left_d;
      game_over_q     <= game_over_d;
      hit_prev_q      <= hit_prev_d;
      prev_idx_q      <= prev_idx_d;
    end
  end

  assign count_restart = count_restart_q;
  assign mole          = mole_q;
  assign score         = score_q;
  assign rounds_left   = rounds_left_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: one instance with the default 10 rounds and one
// with 3 rounds, each fed by its own countdown model driven from its
// count_restart. A bench-side LFSR model predicts every mole.
module tb_mole_round_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  hit;

  logic [31:0] cnt_a, cnt_b;
  logic        restart_a, restart_b;
  logic [3:0]  mole_a, mole_b;
  logic [7:0]  score_a, score_b;
  logic [3:0]  rounds_a, rounds_b;
  logic        over_a, over_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [7:0] score;
    logic [3:0] mole;
    bit         chk_mole;
  } exp_t;

  exp_t sb[$];

  logic [7:0] lfsr_m;
  logic [1:0] prev_m;

  mole_round_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start), .countin(cnt_a), .hit(hit),
    .count_restart(restart_a), .mole(mole_a), .score(score_a),
    .rounds_left(rounds_a), .game_over(over_a)
  );

  mole_round_ctrl #(.NUM_ROUNDS(3), .LFSR_SEED(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .start(start), .countin(cnt_b), .hit(hit),
    .count_restart(restart_b), .mole(mole_b), .score(score_b),
    .rounds_left(rounds_b), .game_over(over_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Five-count down-counter models: restart loads 5, otherwise 5..0 and wrap.
  always @(posedge clk or posedge reset) begin
    if (reset)          cnt_a <= 32'd5;
    else if (restart_a) cnt_a <= 32'd5;
    else                cnt_a <= (cnt_a == 32'd0) ? 32'd5 : cnt_a - 32'd1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset)          cnt_b <= 32'd5;
    else if (restart_b) cnt_b <= 32'd5;
    else                cnt_b <= (cnt_b == 32'd0) ? 32'd5 : cnt_b - 32'd1;
  end

  // Reference LFSR: taps 8,6,5,4 -> bits 7,5,4,3, shifting left.
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 8'hA5;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Called during an ARM cycle: the mole that will show in the next cycle.
  function automatic logic [3:0] predict();
    logic [1:0] idx;
    idx = lfsr_m[1:0];
    if (idx == prev_m) idx = idx + 2'd1;
    prev_m = idx;
    return 4'b0001 << idx;
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    start  = 1'b0;
    hit    = 4'b0000;
    prev_m = 2'd0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the bench at the negedge inside the ARM cycle.
  task automatic begin_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Leaves the bench at the negedge of the PLAY cycle where cnt_a == 0.
  task automatic wait_expiry_a(input string tag);
    int guard;
    guard = 0;
    while (cnt_a != 32'd0 && guard < 12) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (cnt_a != 32'd0) begin
      n_bad++;
      $display("FAIL %s timeout: countdown got %0d want 0", tag, cnt_a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    hit   = 4'b0000;
    prev_m = 2'd0;
    #1;
    n_cmp++; if (mole_a !== 4'd0)     begin n_bad++; $display("FAIL reset_mole: got %b want 0000", mole_a); end
    n_cmp++; if (score_a !== 8'd0)    begin n_bad++; $display("FAIL reset_score: got %0d want 0", score_a); end
    n_cmp++; if (rounds_a !== 4'd10)  begin n_bad++; $display("FAIL reset_rounds: got %0d want 10", rounds_a); end
    n_cmp++; if (over_a !== 1'b0)     begin n_bad++; $display("FAIL reset_game_over: got %b want 0", over_a); end
    n_cmp++; if (restart_a !== 1'b0)  begin n_bad++; $display("FAIL reset_restart: got %b want 0", restart_a); end
    n_cmp++; if (rounds_b !== 4'd3)   begin n_bad++; $display("FAIL reset_rounds_b: got %0d want 3", rounds_b); end
    repeat (3) @(negedge clk);
    n_cmp++; if (restart_a !== 1'b0)  begin n_bad++; $display("FAIL reset_held_start_restart: got %b want 0", restart_a); end
    n_cmp++; if (mole_a !== 4'd0)     begin n_bad++; $display("FAIL reset_held_start_mole: got %b want 0000", mole_a); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (restart_a !== 1'b1)  begin n_bad++; $display("FAIL reset_release_start: got %b want 1", restart_a); end
    start = 1'b0;
    do_reset();
  endtask

  task automatic test_basic_round();
    logic [3:0] exp_m;
    exp_t e;
    do_reset();
    begin_game();
    n_cmp++; if (restart_a !== 1'b1) begin n_bad++; $display("FAIL basic_restart_arm: got %b want 1", restart_a); end
    n_cmp++; if (mole_a !== 4'd0)    begin n_bad++; $display("FAIL basic_mole_arm: got %b want 0000", mole_a); end
    exp_m = predict();
    @(negedge clk);
    n_cmp++; if (restart_a !== 1'b0) begin n_bad++; $display("FAIL basic_restart_play: got %b want 0", restart_a); end
    n_cmp++; if (mole_a !== exp_m)   begin n_bad++; $display("FAIL basic_mole_play: got %b want %b", mole_a, exp_m); end
    n_cmp++; if (cnt_a !== 32'd5)    begin n_bad++; $display("FAIL basic_countdown_load: got %0d want 5", cnt_a); end
    hit = exp_m;
    sb.push_back('{tag: "basic_hit", score: 8'd1, mole: 4'd0, chk_mole: 1'b1});
    @(negedge clk);
    hit = 4'b0000;
    e = sb.pop_front();
    n_cmp++; if (score_a !== e.score)   begin n_bad++; $display("FAIL %s score: got %0d want %0d", e.tag, score_a, e.score); end
    n_cmp++; if (mole_a !== e.mole)     begin n_bad++; $display("FAIL %s mole: got %b want %b", e.tag, mole_a, e.mole); end
    n_cmp++; if (rounds_a !== 4'd10)    begin n_bad++; $display("FAIL basic_rounds: got %0d want 10", rounds_a); end
  endtask

  task automatic test_misses();
    logic [3:0] exp_m, wrong, stim;
    exp_t e;
    do_reset();
    begin_game();
    exp_m = predict();
    wrong = {exp_m[2:0], exp_m[3]};
    @(negedge clk);
    // Steps start in the first PLAY cycle (countdown 5); step 5 hits expiry.
    for (int i = 0; i < 7; i++) begin
      e.chk_mole = 1'b1;
      case (i)
        0:       begin stim = wrong;         e.score = 8'd0; e.mole = exp_m; e.tag = "miss_wrong";   end
        1, 3:    begin stim = 4'b0000;       e.score = 8'd0; e.mole = exp_m; e.tag = "miss_release"; end
        2:       begin stim = exp_m | wrong; e.score = 8'd0; e.mole = exp_m; e.tag = "miss_extra";   end
        4:       begin stim = exp_m;         e.score = 8'd1; e.mole = 4'd0;  e.tag = "hold_first";   end
        5:       begin stim = exp_m;         e.score = 8'd1; e.mole = 4'd0;  e.tag = "hold_second";  end
        default: begin stim = exp_m;         e.score = 8'd1; e.mole = 4'd0;  e.tag = "hold_third";
                       e.chk_mole = 1'b0; end
      endcase
      hit = stim;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++; if (score_a !== e.score) begin n_bad++; $display("FAIL %s score: got %0d want %0d", e.tag, score_a, e.score); end
      if (e.chk_mole) begin
        n_cmp++; if (mole_a !== e.mole) begin n_bad++; $display("FAIL %s mole: got %b want %b", e.tag, mole_a, e.mole); end
      end
    end
    hit = 4'b0000;
  endtask

  task automatic test_hit_and_expiry();
    logic [3:0] exp_m, next_m;
    do_reset();
    begin_game();
    exp_m = predict();
    @(negedge clk);
    wait_expiry_a("hit_expiry");
    hit = exp_m;
    @(negedge clk);
    hit = 4'b0000;
    n_cmp++; if (score_a !== 8'd1)   begin n_bad++; $display("FAIL hx_score: got %0d want 1", score_a); end
    n_cmp++; if (rounds_a !== 4'd9)  begin n_bad++; $display("FAIL hx_rounds: got %0d want 9", rounds_a); end
    n_cmp++; if (restart_a !== 1'b1) begin n_bad++; $display("FAIL hx_restart: got %b want 1", restart_a); end
    n_cmp++; if (mole_a !== 4'd0)    begin n_bad++; $display("FAIL hx_mole_arm: got %b want 0000", mole_a); end
    next_m = predict();
    @(negedge clk);
    n_cmp++; if (mole_a !== next_m)  begin n_bad++; $display("FAIL hx_next_mole: got %b want %b", mole_a, next_m); end
    n_cmp++; if (restart_a !== 1'b0) begin n_bad++; $display("FAIL hx_restart_drop: got %b want 0", restart_a); end
  endtask

  task automatic test_full_game();
    logic [3:0] exp_m, prev_obs;
    int guard;
    do_reset();
    begin_game();
    prev_obs = 4'd0;
    for (int r = 0; r < 3; r++) begin
      n_cmp++; if (restart_b !== 1'b1) begin n_bad++; $display("FAIL game_r%0d_restart: got %b want 1", r, restart_b); end
      exp_m = predict();
      @(negedge clk);
      n_cmp++; if (mole_b !== exp_m) begin n_bad++; $display("FAIL game_r%0d_mole: got %b want %b", r, mole_b, exp_m); end
      if (r > 0) begin
        n_cmp++; if (mole_b === prev_obs) begin n_bad++; $display("FAIL game_r%0d_repeat: got %b want not %b", r, mole_b, prev_obs); end
      end
      prev_obs = mole_b;
      guard = 0;
      while (cnt_b != 32'd0 && guard < 12) begin
        @(negedge clk);
        guard++;
      end
      n_cmp++; if (cnt_b != 32'd0) begin n_bad++; $display("FAIL game_r%0d timeout: countdown got %0d want 0", r, cnt_b); end
      @(negedge clk);
    end
    n_cmp++; if (over_b !== 1'b1)    begin n_bad++; $display("FAIL game_over_rise: got %b want 1", over_b); end
    n_cmp++; if (mole_b !== 4'd0)    begin n_bad++; $display("FAIL game_over_mole: got %b want 0000", mole_b); end
    n_cmp++; if (rounds_b !== 4'd0)  begin n_bad++; $display("FAIL game_over_rounds: got %0d want 0", rounds_b); end
    n_cmp++; if (restart_b !== 1'b0) begin n_bad++; $display("FAIL game_over_restart: got %b want 0", restart_b); end
    n_cmp++; if (rounds_a !== 4'd7)  begin n_bad++; $display("FAIL game_ten_rounds: got %0d want 7", rounds_a); end
    @(negedge clk);
    n_cmp++; if (over_b !== 1'b1)    begin n_bad++; $display("FAIL game_over_hold: got %b want 1", over_b); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (restart_b !== 1'b1) begin n_bad++; $display("FAIL regame_restart: got %b want 1", restart_b); end
    n_cmp++; if (score_b !== 8'd0)   begin n_bad++; $display("FAIL regame_score: got %0d want 0", score_b); end
    n_cmp++; if (rounds_b !== 4'd3)  begin n_bad++; $display("FAIL regame_rounds: got %0d want 3", rounds_b); end
    n_cmp++; if (over_b !== 1'b0)    begin n_bad++; $display("FAIL regame_over: got %b want 0", over_b); end
  endtask

  task automatic test_reset_mid_play();
    logic [3:0] exp_m;
    do_reset();
    begin_game();
    exp_m = predict();
    @(negedge clk);
    n_cmp++; if (mole_a !== exp_m)   begin n_bad++; $display("FAIL rmp_mole_lit: got %b want %b", mole_a, exp_m); end
    hit = 4'b1111;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (mole_a !== 4'd0)    begin n_bad++; $display("FAIL rmp_async_mole: got %b want 0000", mole_a); end
    n_cmp++; if (score_a !== 8'd0)   begin n_bad++; $display("FAIL rmp_async_score: got %0d want 0", score_a); end
    n_cmp++; if (rounds_a !== 4'd10) begin n_bad++; $display("FAIL rmp_async_rounds: got %0d want 10", rounds_a); end
    prev_m = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (restart_a !== 1'b0) begin n_bad++; $display("FAIL rmp_idle_restart: got %b want 0", restart_a); end
    n_cmp++; if (score_a !== 8'd0)   begin n_bad++; $display("FAIL rmp_idle_score: got %0d want 0", score_a); end
    begin_game();
    exp_m = predict();
    @(negedge clk);
    n_cmp++; if (mole_a !== exp_m)   begin n_bad++; $display("FAIL rmp_new_mole: got %b want %b", mole_a, exp_m); end
    repeat (6) @(negedge clk);
    n_cmp++; if (score_a !== 8'd0)   begin n_bad++; $display("FAIL rmp_held_button: got %0d want 0", score_a); end
    hit = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_round();
    test_misses();
    test_hit_and_expiry();
    test_full_game();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round sequencer for the whack-a-mole game. It is the consumer and controller of the five-count down-counter: it restarts the countdown at the start of each round, lights one mole per round, and scores debounced button hits. It treats a countdown value of 0 as round expiry, runs a fixed number of rounds, then raises game-over. It sits between the countdown counter, the button debouncers and the LED/score display logic, all on the same game clock.

## Interface
- NUM_ROUNDS, 10: rounds per game (1..15).
- LFSR_SEED, 8'hA5: nonzero reset value of the mole-select LFSR.
- clk  input  1  game clock; the same clock that decrements the countdown.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  level; starts a game from IDLE or OVER.
- countin  input  32  current countdown value (5 down to 0, then wraps to 5).
- hit  input  4  debounced button levels, one per hole.
- count_restart  output  1  registered one-cycle pulse; drives the countdown's reset.
- mole  output  4  one-hot lit hole; 0 when no mole is shown.
- score  output  8  successful hits this game, saturating at 255.
- rounds_left  output  4  rounds not yet expired.
- game_over  output  1  high while in OVER.

## Operation
- States:
  - IDLE (reset state).
  - ARM: restart the countdown and choose a hole.
  - PLAY: mole lit and awaiting a hit.
  - WAIT: mole has been hit; waiting for expiry.
  - OVER: game finished.
- Transitions:
  - IDLE/OVER, start=1 -> ARM. Score clears to 0 and rounds_left loads NUM_ROUNDS.
  - ARM -> PLAY, unconditionally, after one cycle.
  - PLAY, valid hit -> WAIT. The mole clears.
  - PLAY/WAIT, countin==0 (expiry) -> rounds_left decrements. Next state is OVER if the result is 0, else ARM.
  - start is ignored outside IDLE/OVER.
- Expiry is ignored in ARM, because countin is stale while the restart takes effect.
- Hit edge: hit_edge = hit & ~hit_prev. hit_prev is registered and resets to 0.
- Valid hit:
  - Only in PLAY.
  - hit_edge must equal mole exactly. Any other set bit, including an extra button, is a miss.
  - A miss has no effect; the mole stays lit.
- Hit and expiry on the same cycle in PLAY: score the hit first, then apply the expiry transition.
- Mole select:
  - The 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every cycle, including in IDLE.
  - Candidate hole index = lfsr[1:0].
  - If the candidate equals the previous round's index, use (idx+1) mod 4 instead, so consecutive moles always differ.
  - The previous index resets to 0.
- Score: +1 per valid hit, held at 255 once reached.
- Reset mid-game: all outputs take their reset values asynchronously, and the state returns to IDLE.

## Timing
- Reset values:
  - count_restart=0, mole=0, score=0, rounds_left=NUM_ROUNDS, game_over=0.
  - hit_prev=0, LFSR=LFSR_SEED, state=IDLE.
- All outputs are registered; there are no combinational paths from input to output.
- count_restart is high for exactly the one cycle spent in ARM. The countdown reads 5 on the following cycle.
- mole becomes valid in the first cycle of PLAY, i.e. 2 clocks after start is sampled.
- Hit response: a hit that rises before edge N is sampled at edge N. score and mole update at edge N and are visible after it. Latency is 1 clock.
- Round length: ARM (1 cycle), then PLAY/WAIT while countin counts 5 down to 0. Expiry is sampled in the cycle countin==0, so one round is 7 cycles.
- game_over rises in the cycle after the final expiry and holds until start or reset.

## Structure
- Package whack_pkg holds:
  - the state encoding constants (IDLE, ARM, PLAY, WAIT, OVER);
  - NUM_HOLES=4;
  - the LFSR tap mask;
  - the countdown terminal value 0 and load value 5.
- One sub-module, mole_lfsr: 8-bit LFSR with seed parameter, always enabled, exposing the 2-bit hole index.
- The FSM, edge detection, score and round counters stay in mole_round_ctrl.

## Test plan
- Reset check: assert reset -> mole=0, score=0, rounds_left=10, game_over=0, count_restart=0. Reset with start held -> stays in IDLE until reset releases.
- Basic round, with a countdown model attached to count_restart: start=1 -> count_restart high one cycle, mole one-hot 2 clocks after start. Press the matching button -> score=1 and mole=0 the next cycle.
- Misses: press a non-matching button, then the matching plus one extra button -> score stays 0 and mole stays lit. Hold the correct button for 3 cycles -> score increments only once.
- Simultaneous hit and expiry: valid hit in the cycle countin==0 -> score=1, rounds_left 10->9, next state ARM with count_restart pulsed.
- Full game, NUM_ROUNDS=3, no hits:
  - game_over=1 after the 3rd expiry, with mole=0 and rounds_left=0.
  - Consecutive moles are all different.
  - start -> score=0, rounds_left=3, new round begins.
- Reset mid-PLAY, with a button held across reset release: outputs clear immediately, no score change, state is IDLE, and the held button never scores.
